// File: rtl/adc_result_fifo.sv
// adc_result_fifo: captures finished ADC results into a small first-word-fall-through
// FIFO and exposes them on a valid/ready read port. It also reports the fill level, a
// sticky overflow flag, a saturating drop counter and a level-threshold interrupt.
//
// Read handshake: rd_valid_out is high whenever the FIFO holds at least one entry, and
// rd_data_out then shows the oldest entry. An entry is consumed only in a cycle where
// rd_valid_out and rd_ready_in are both high. While rd_valid_out is high and rd_ready_in
// is low, rd_valid_out and rd_data_out stay unchanged. rd_ready_in has no effect while
// rd_valid_out is low.
module adc_result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_dig_in,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  conv_finished_in,
    input  logic                  clear_in,
    input  logic                  rd_ready_in,
    output logic                  rd_valid_out,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic [ADDR_WIDTH:0]   level_out,
    output logic                  overflow_out,
    output logic [7:0]            drop_count_out,
    input  logic [ADDR_WIDTH:0]   irq_threshold_in,
    output logic                  irq_out
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] storage_q [DEPTH];
    logic [DATA_WIDTH-1:0] storage_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;
    logic                  fin_q, fin_d;
    logic                  armed_q, armed_d;
    logic                  irq_q, irq_d;

    logic push_req;
    logic push_acc;
    logic pop;
    logic full;
    logic valid;

    // Next-state logic: clear beats normal traffic; push/pop update pointers and level.
    always_comb begin
        // armed_q blocks a level that was already high when reset released from being
        // mistaken for a new conversion; it arms once conv_finished_in is seen low.
        push_req = conv_finished_in & ~fin_q & armed_q;
        valid    = (level_q != '0);
        pop      = valid & rd_ready_in;
        full     = (level_q == FULL_LEVEL);
        push_acc = push_req & (~full | pop);

        storage_d  = storage_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        fin_d      = conv_finished_in;
        armed_d    = armed_q | ~conv_finished_in;

        if (clear_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_d[i] = '0;
            end
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            // When full with a simultaneous pop, wr_ptr equals rd_ptr, so the slot the
            // consumer is taking this cycle is the one being refilled.
            if (push_acc) begin
                storage_d[wr_ptr_q] = result_in;
                wr_ptr_d            = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({push_acc, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (push_req && !push_acc) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end

        irq_d = (irq_threshold_in != '0) && (level_d >= irq_threshold_in);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_dig_in) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            fin_q      <= 1'b0;
            armed_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= storage_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            fin_q      <= fin_d;
            armed_q    <= armed_d;
            irq_q      <= irq_d;
        end
    end

    assign rd_valid_out   = (level_q != '0);
    assign rd_data_out    = storage_q[rd_ptr_q];
    assign level_out      = level_q;
    assign overflow_out   = overflow_q;
    assign drop_count_out = drop_cnt_q;
    assign irq_out        = irq_q;

endmodule

// File: tb/tb_adc_result_fifo.sv
// Testbench for adc_result_fifo: scenario tasks with a scoreboard queue of expected
// read data, plus a small model of drops for the status outputs.
module tb_adc_result_fifo;

    logic        clk_dig_in = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] result_in = '0;
    logic        conv_finished_in = 1'b0;
    logic        clear_in = 1'b0;
    logic        rd_ready_in = 1'b0;
    logic        rd_valid_out;
    logic [15:0] rd_data_out;
    logic [3:0]  level_out;
    logic        overflow_out;
    logic [7:0]  drop_count_out;
    logic [3:0]  irq_threshold_in = '0;
    logic        irq_out;

    logic [15:0] exp_q[$];
    int          exp_drops = 0;
    int          total = 0;
    int          bad = 0;

    adc_result_fifo dut (
        .clk_dig_in       (clk_dig_in),
        .rst_n            (rst_n),
        .result_in        (result_in),
        .conv_finished_in (conv_finished_in),
        .clear_in         (clear_in),
        .rd_ready_in      (rd_ready_in),
        .rd_valid_out     (rd_valid_out),
        .rd_data_out      (rd_data_out),
        .level_out        (level_out),
        .overflow_out     (overflow_out),
        .drop_count_out   (drop_count_out),
        .irq_threshold_in (irq_threshold_in),
        .irq_out          (irq_out)
    );

    // Clock
    always #5 clk_dig_in = ~clk_dig_in;

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_dig_in);
        #1;
    endtask

    // One conversion: rising edge of conv_finished_in, then low again.
    task automatic do_conv(input logic [15:0] d);
        result_in = d;
        conv_finished_in = 1'b1;
        tick();
        conv_finished_in = 1'b0;
        tick();
        if (exp_q.size() < 8) exp_q.push_back(d);
        else exp_drops++;
    endtask

    // Pop one entry, comparing the head against the scoreboard first.
    task automatic pop_one(input string name);
        total++;
        if (rd_valid_out !== 1'b1 || rd_data_out !== exp_q[0]) begin
            bad++;
            $display("FAIL %s got valid=%0b data=%h exp valid=1 data=%h", name, rd_valid_out, rd_data_out, exp_q[0]);
        end
        rd_ready_in = 1'b1;
        tick();
        rd_ready_in = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        exp_q.delete();
        exp_drops = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total++;
        if ({rd_valid_out, rd_data_out, level_out, overflow_out, drop_count_out, irq_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%0b data=%h level=%0d ovf=%0b drops=%0d irq=%0b exp all 0",
                     rd_valid_out, rd_data_out, level_out, overflow_out, drop_count_out, irq_out);
        end
        tick();
    endtask

    task automatic test_single_push();
        result_in = 16'h2CA8;
        conv_finished_in = 1'b1;
        tick();
        exp_q.push_back(16'h2CA8);
        total++;
        if (rd_valid_out !== 1'b1 || rd_data_out !== 16'h2CA8 || level_out !== 4'd1) begin
            bad++;
            $display("FAIL single_latency got valid=%0b data=%h level=%0d exp 1/2ca8/1", rd_valid_out, rd_data_out, level_out);
        end
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (level_out !== 4'd1) begin
            bad++;
            $display("FAIL single_held_level got=%0d exp=1", level_out);
        end
        conv_finished_in = 1'b0;
        pop_one("single_pop");
        total++;
        if (rd_valid_out !== 1'b0 || level_out !== 4'd0) begin
            bad++;
            $display("FAIL single_empty got valid=%0b level=%0d exp 0/0", rd_valid_out, level_out);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) do_conv(16'(i));
        total++;
        if (level_out !== 4'd8 || overflow_out !== 1'b1 || drop_count_out !== 8'(exp_drops)) begin
            bad++;
            $display("FAIL ovf_status got level=%0d ovf=%0b drops=%0d exp 8/1/%0d", level_out, overflow_out, drop_count_out, exp_drops);
        end
        for (int i = 0; i < 8; i++) pop_one("ovf_drain");
        total++;
        if (level_out !== 4'd0 || rd_valid_out !== 1'b0 || overflow_out !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got level=%0d valid=%0b ovf=%0b exp 0/0/1", level_out, rd_valid_out, overflow_out);
        end
        do_clear();
        total++;
        if (overflow_out !== 1'b0 || drop_count_out !== 8'd0) begin
            bad++;
            $display("FAIL ovf_clear got ovf=%0b drops=%0d exp 0/0", overflow_out, drop_count_out);
        end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 8; i++) do_conv(16'($urandom_range(16'h0100, 16'hFFFF)));
        total++;
        if (rd_data_out !== exp_q[0] || level_out !== 4'd8) begin
            bad++;
            $display("FAIL full_head got data=%h level=%0d exp %h/8", rd_data_out, level_out, exp_q[0]);
        end
        result_in = 16'hBEEF;
        conv_finished_in = 1'b1;
        rd_ready_in = 1'b1;
        tick();
        conv_finished_in = 1'b0;
        rd_ready_in = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(16'hBEEF);
        total++;
        if (level_out !== 4'd8 || overflow_out !== 1'b0 || drop_count_out !== 8'd0) begin
            bad++;
            $display("FAIL full_pushpop got level=%0d ovf=%0b drops=%0d exp 8/0/0", level_out, overflow_out, drop_count_out);
        end
        for (int i = 0; i < 7; i++) pop_one("full_drain");
        total++;
        if (rd_data_out !== 16'hBEEF || level_out !== 4'd1) begin
            bad++;
            $display("FAIL full_reuse got data=%h level=%0d exp beef/1", rd_data_out, level_out);
        end
        pop_one("full_last");
    endtask

    task automatic test_irq();
        irq_threshold_in = 4'd3;
        do_conv(16'h1111);
        do_conv(16'h2222);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL irq_below got=%0b exp=0", irq_out);
        end
        result_in = 16'h3333;
        conv_finished_in = 1'b1;
        tick();
        conv_finished_in = 1'b0;
        exp_q.push_back(16'h3333);
        total++;
        if (irq_out !== 1'b1 || level_out !== 4'd3) begin
            bad++;
            $display("FAIL irq_rise got irq=%0b level=%0d exp 1/3", irq_out, level_out);
        end
        tick();
        pop_one("irq_pop");
        total++;
        if (irq_out !== 1'b0 || level_out !== 4'd2) begin
            bad++;
            $display("FAIL irq_fall got irq=%0b level=%0d exp 0/2", irq_out, level_out);
        end
        do_conv(16'h4444);
        do_conv(16'h5555);
        total++;
        if (irq_out !== 1'b1 || level_out !== 4'd4) begin
            bad++;
            $display("FAIL irq_level4 got irq=%0b level=%0d exp 1/4", irq_out, level_out);
        end
        irq_threshold_in = 4'd0;
        tick();
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL irq_disable got=%0b exp=0", irq_out);
        end
        do_clear();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 9; i++) do_conv(16'(16'hA000 + i));
        for (int i = 0; i < 3; i++) pop_one("clr_pre_pop");
        total++;
        if (level_out !== 4'd5 || overflow_out !== 1'b1) begin
            bad++;
            $display("FAIL clr_setup got level=%0d ovf=%0b exp 5/1", level_out, overflow_out);
        end
        result_in = 16'hC1C1;
        conv_finished_in = 1'b1;
        rd_ready_in = 1'b1;
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        rd_ready_in = 1'b0;
        exp_q.delete();
        exp_drops = 0;
        total++;
        if (level_out !== 4'd0 || rd_valid_out !== 1'b0 || overflow_out !== 1'b0 ||
            drop_count_out !== 8'd0 || rd_data_out !== 16'h0000) begin
            bad++;
            $display("FAIL clr_result got level=%0d valid=%0b ovf=%0b drops=%0d data=%h exp all 0",
                     level_out, rd_valid_out, overflow_out, drop_count_out, rd_data_out);
        end
        tick();
        tick();
        total++;
        if (level_out !== 4'd0) begin
            bad++;
            $display("FAIL clr_no_repush got level=%0d exp=0", level_out);
        end
        conv_finished_in = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) do_conv(16'(16'h7000 + i));
        result_in = 16'h7003;
        conv_finished_in = 1'b1;
        tick();
        exp_q.push_back(16'h7003);
        total++;
        if (level_out !== 4'd4) begin
            bad++;
            $display("FAIL rstmid_setup got level=%0d exp=4", level_out);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_drops = 0;
        total++;
        if ({rd_valid_out, rd_data_out, level_out, overflow_out, drop_count_out, irq_out} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs got valid=%0b data=%h level=%0d ovf=%0b drops=%0d irq=%0b exp all 0",
                     rd_valid_out, rd_data_out, level_out, overflow_out, drop_count_out, irq_out);
        end
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (level_out !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_no_push got level=%0d exp=0", level_out);
        end
        conv_finished_in = 1'b0;
        tick();
        do_conv(16'h5A5A);
        total++;
        if (level_out !== 4'd1) begin
            bad++;
            $display("FAIL rstmid_next_push got level=%0d exp=1", level_out);
        end
        pop_one("rstmid_pop");
    endtask

    // Back-to-back conversions interleaved with random ready, checked via scoreboard.
    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            do_conv(16'($urandom_range(0, 16'hFFFF)));
            if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) pop_one("b2b_pop");
        end
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() > 0) pop_one("b2b_drain");
        end
        total++;
        if (level_out !== 4'd0 || drop_count_out !== 8'(exp_drops)) begin
            bad++;
            $display("FAIL b2b_end got level=%0d drops=%0d exp 0/%0d", level_out, drop_count_out, exp_drops);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_overflow();
        test_push_pop_full();
        test_irq();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
